// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program loader: state encoding,
// HLT opcode and the position of the opcode field in an instruction word.
package mips_pkg;

  // Loader state encoding, kept as plain constants for legacy tools
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REGINIT = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_LAUNCH  = 3'd3;
  localparam state_t ST_RUN     = 3'd4;
  localparam state_t ST_DONE    = 3'd5;
  localparam state_t ST_ERR     = 3'd6;

  // Opcode of the HLT instruction and where the opcode sits in a word
  localparam logic [5:0] HLT_OPCODE = 6'h3F;
  localparam int         OP_HI      = 31;
  localparam int         OP_LO      = 26;

  // Size of the core register file that gets seeded before a load
  localparam int NUM_REGS = 32;

  // Extracts the opcode field from a 32-bit instruction word
  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader for a small MIPS core: seeds the register file with
// Rk=k, streams a program into instruction memory, insists that a HLT
// instruction was loaded, then releases the core and waits for it to halt.
module prog_loader
  import mips_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [5:0] HLT_OP = HLT_OPCODE
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              reg_we,
  output logic [4:0]        reg_waddr,
  output logic [31:0]       reg_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_halt,
  output logic              core_init,
  input  logic              core_halted,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [4:0]      LAST_REG = 5'(NUM_REGS - 1);

  state_t     state;
  logic       hlt_seen;
  logic [4:0] reg_k;
  logic       mem_full;
  logic       xfer;
  logic       word_is_hlt;

  // Handshake and write-port decode; a full memory refuses further words
  always_comb begin
    mem_full    = (word_count == DEPTH);
    in_ready    = (state == ST_LOAD) && !mem_full;
    xfer        = in_valid && in_ready;
    word_is_hlt = (opcode_of(in_data) == HLT_OP);
    reg_we      = (state == ST_REGINIT);
    reg_waddr   = reg_k;
    reg_wdata   = {27'd0, reg_k};
    mem_we      = xfer;
    mem_addr    = word_count[ADDR_W-1:0];
    mem_wdata   = in_data;
    core_halt   = (state != ST_RUN);
    core_init   = (state == ST_LAUNCH);
    done        = (state == ST_DONE);
    err         = (state == ST_ERR);
  end

  // Sequencer: register seeding, program load, launch and run supervision
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_count <= '0;
      hlt_seen   <= 1'b0;
      reg_k      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_REGINIT;
            word_count <= '0;
            hlt_seen   <= 1'b0;
            reg_k      <= '0;
          end
        end
        ST_REGINIT: begin
          reg_k <= reg_k + 5'd1;
          if (reg_k == LAST_REG) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (mem_full) begin
            state <= ST_ERR;
          end else if (xfer) begin
            word_count <= word_count + (ADDR_W+1)'(1);
            if (word_is_hlt) begin
              hlt_seen <= 1'b1;
            end
            if (in_last) begin
              state <= (hlt_seen || word_is_hlt) ? ST_LAUNCH : ST_ERR;
            end
          end
        end
        ST_LAUNCH: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (core_halted) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
